// File: rtl/systolic_mm_engine.sv
`default_nettype none
// systolic_mm_engine: output-stationary ROWS x COLS systolic array computing C (+)= A*B,
// with internal operand skew, start/done control and a back-pressured row-by-row drain.
module systolic_mm_engine #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40,
    parameter int KLEN_W = 12
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   start,
    input  logic                                   acc_mode,
    input  logic [KLEN_W-1:0]                      k_len,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [ROWS*DATA_W-1:0]                 a_vec,
    input  logic [COLS*DATA_W-1:0]                 b_vec,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [COLS*ACC_W-1:0]                  out_row,
    output logic [(ROWS > 1 ? $clog2(ROWS) : 1)-1:0] out_idx,
    output logic                                   busy,
    output logic                                   done
);

    localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int FL_W  = $clog2(ROWS + COLS);
    localparam logic [FL_W-1:0] FL_LAST = FL_W'(ROWS + COLS - 2);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [KLEN_W-1:0] klen_q, klen_d;
    logic [KLEN_W-1:0] beat_q, beat_d;
    logic [FL_W-1:0]   flush_q, flush_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              done_q, done_d;

    logic w_accept;
    logic w_clear;
    logic w_out_hs;

    assign w_accept = in_valid && (state_q == S_LOAD);
    assign w_clear  = start && !acc_mode && (state_q == S_IDLE);
    assign w_out_hs = out_ready && (state_q == S_DRAIN);

    always_comb begin
        state_d = state_q;
        klen_d  = klen_q;
        beat_d  = beat_q;
        flush_d = flush_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    klen_d  = k_len;
                    beat_d  = '0;
                    idx_d   = '0;
                    state_d = (k_len == '0) ? S_DRAIN : S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_accept) begin
                    if (beat_q == klen_q - KLEN_W'(1)) begin
                        beat_d  = '0;
                        flush_d = '0;
                        state_d = S_FLUSH;
                    end else begin
                        beat_d = beat_q + KLEN_W'(1);
                    end
                end
            end
            S_FLUSH: begin
                // the last beat lands in PE(ROWS-1,COLS-1) on the same edge we leave FLUSH
                if (flush_q == FL_LAST) begin
                    state_d = S_DRAIN;
                end else begin
                    flush_d = flush_q + FL_W'(1);
                end
            end
            S_DRAIN: begin
                if (w_out_hs) begin
                    if (idx_q == IDX_W'(ROWS - 1)) begin
                        idx_d   = '0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            klen_q  <= '0;
            beat_q  <= '0;
            flush_q <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            klen_q  <= klen_d;
            beat_q  <= beat_d;
            flush_q <= flush_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    // Operand skew: lane r of A waits r extra cycles, lane c of B waits c extra cycles.
    logic [DATA_W-1:0] w_a_head   [ROWS];
    logic              w_a_head_v [ROWS];
    logic [DATA_W-1:0] w_b_head   [COLS];
    logic              w_b_head_v [COLS];

    for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
        if (r == 0) begin : g_direct
            assign w_a_head[r]   = a_vec[r*DATA_W +: DATA_W];
            assign w_a_head_v[r] = w_accept;
        end else begin : g_chain
            logic [DATA_W-1:0] sk_q  [r];
            logic              skv_q [r];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < r; i++) begin
                        sk_q[i]  <= '0;
                        skv_q[i] <= 1'b0;
                    end
                end else begin
                    sk_q[0]  <= a_vec[r*DATA_W +: DATA_W];
                    skv_q[0] <= w_accept;
                    for (int i = 1; i < r; i++) begin
                        sk_q[i]  <= sk_q[i-1];
                        skv_q[i] <= skv_q[i-1];
                    end
                end
            end
            assign w_a_head[r]   = sk_q[r-1];
            assign w_a_head_v[r] = skv_q[r-1];
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_b_skew
        if (c == 0) begin : g_direct
            assign w_b_head[c]   = b_vec[c*DATA_W +: DATA_W];
            assign w_b_head_v[c] = w_accept;
        end else begin : g_chain
            logic [DATA_W-1:0] sk_q  [c];
            logic              skv_q [c];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < c; i++) begin
                        sk_q[i]  <= '0;
                        skv_q[i] <= 1'b0;
                    end
                end else begin
                    sk_q[0]  <= b_vec[c*DATA_W +: DATA_W];
                    skv_q[0] <= w_accept;
                    for (int i = 1; i < c; i++) begin
                        sk_q[i]  <= sk_q[i-1];
                        skv_q[i] <= skv_q[i-1];
                    end
                end
            end
            assign w_b_head[c]   = sk_q[c-1];
            assign w_b_head_v[c] = skv_q[c-1];
        end
    end

    // a_q/b_q hold the operands currently presented to PE(r,c)
    logic [DATA_W-1:0]          a_q   [ROWS][COLS];
    logic                       av_q  [ROWS][COLS];
    logic [DATA_W-1:0]          b_q   [ROWS][COLS];
    logic                       bv_q  [ROWS][COLS];
    logic [ACC_W-1:0]           acc_q [ROWS][COLS];
    logic signed [2*DATA_W-1:0] w_mul [ROWS][COLS];

    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                w_mul[r][c] = $signed({{DATA_W{a_q[r][c][DATA_W-1]}}, a_q[r][c]})
                            * $signed({{DATA_W{b_q[r][c][DATA_W-1]}}, b_q[r][c]});
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    a_q[r][c]   <= '0;
                    av_q[r][c]  <= 1'b0;
                    b_q[r][c]   <= '0;
                    bv_q[r][c]  <= 1'b0;
                    acc_q[r][c] <= '0;
                end
            end
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                a_q[r][0]  <= w_a_head[r];
                av_q[r][0] <= w_a_head_v[r];
                for (int c = 1; c < COLS; c++) begin
                    a_q[r][c]  <= a_q[r][c-1];
                    av_q[r][c] <= av_q[r][c-1];
                end
            end
            for (int c = 0; c < COLS; c++) begin
                b_q[0][c]  <= w_b_head[c];
                bv_q[0][c] <= w_b_head_v[c];
                for (int r = 1; r < ROWS; r++) begin
                    b_q[r][c]  <= b_q[r-1][c];
                    bv_q[r][c] <= bv_q[r-1][c];
                end
            end
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    if (w_clear) begin
                        acc_q[r][c] <= '0;
                    end else if (av_q[r][c] && bv_q[r][c]) begin
                        acc_q[r][c] <= acc_q[r][c] + ACC_W'(w_mul[r][c]);
                    end
                end
            end
        end
    end

    always_comb begin
        out_row = '0;
        if (state_q == S_DRAIN) begin
            for (int c = 0; c < COLS; c++) begin
                out_row[c*ACC_W +: ACC_W] = acc_q[idx_q][c];
            end
        end
    end

    assign in_ready  = (state_q == S_LOAD);
    assign out_valid = (state_q == S_DRAIN);
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign out_idx   = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_systolic_mm_engine.sv
`default_nettype none
// Bench for systolic_mm_engine: table of directed tiles, random tiles against a matrix
// model, plus reset-abort sequences during LOAD and DRAIN.
module tb_systolic_mm_engine;

    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int DATA_W = 16;
    localparam int ACC_W  = 40;
    localparam int KLEN_W = 12;
    localparam int CW     = COLS * ACC_W;
    localparam int MAXK   = 16;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   start = 1'b0;
    logic                   acc_mode = 1'b0;
    logic [KLEN_W-1:0]      k_len = '0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [ROWS*DATA_W-1:0] a_vec = '0;
    logic [COLS*DATA_W-1:0] b_vec = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [CW-1:0]          out_row;
    logic [1:0]             out_idx;
    logic                   busy;
    logic                   done;

    systolic_mm_engine #(
        .ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ACC_W(ACC_W), .KLEN_W(KLEN_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .acc_mode(acc_mode), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready), .a_vec(a_vec), .b_vec(b_vec),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_idx(out_idx),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        bit     acc;
        int     k;
        int     a_kind;   // 0 constant, 1 identity, 2 random
        int     b_kind;   // 0 constant, 1 value 4k+c+1, 2 random
        int     a_val;
        int     b_val;
        int     bub;
        int     stall;
        bit     has_exp;
        longint exp_val;
    } tile_t;

    int n_vec = 0;
    int n_err = 0;

    logic signed [DATA_W-1:0] op_a [MAXK][ROWS];
    logic signed [DATA_W-1:0] op_b [MAXK][COLS];
    logic [ACC_W-1:0]         mdl  [ROWS][COLS];
    bit                       use_exp = 1'b0;
    logic [CW-1:0]            exp_row = '0;
    tile_t                    tbl [9];

    task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic tile_t mk(bit acc, int k, int ak, int bk, int av, int bv,
                                 int bub, int stall, bit he, longint ev);
        tile_t t;
        t.acc = acc; t.k = k; t.a_kind = ak; t.b_kind = bk; t.a_val = av; t.b_val = bv;
        t.bub = bub; t.stall = stall; t.has_exp = he; t.exp_val = ev;
        return t;
    endfunction

    function automatic logic [CW-1:0] model_row(int r);
        logic [CW-1:0] v;
        v = '0;
        for (int c = 0; c < COLS; c++) v[c*ACC_W +: ACC_W] = mdl[r][c];
        return v;
    endfunction

    task automatic clear_model();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) mdl[r][c] = '0;
    endtask

    task automatic gen_ops(input tile_t t);
        for (int i = 0; i < t.k; i++) begin
            for (int r = 0; r < ROWS; r++)
                op_a[i][r] = (t.a_kind == 0) ? DATA_W'(t.a_val) :
                             (t.a_kind == 1) ? DATA_W'((r == i) ? 1 : 0) : DATA_W'($urandom);
            for (int c = 0; c < COLS; c++)
                op_b[i][c] = (t.b_kind == 0) ? DATA_W'(t.b_val) :
                             (t.b_kind == 1) ? DATA_W'(4*i + c + 1) : DATA_W'($urandom);
        end
        use_exp = t.has_exp;
        exp_row = '0;
        for (int c = 0; c < COLS; c++) exp_row[c*ACC_W +: ACC_W] = t.exp_val[ACC_W-1:0];
    endtask

    // C = (acc ? C : 0) + A*B, wrapped to ACC_W bits
    task automatic model_tile(input bit acc, input int k);
        longint p;
        if (!acc) clear_model();
        for (int i = 0; i < k; i++)
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) begin
                    p = longint'(op_a[i][r]) * longint'(op_b[i][c]);
                    mdl[r][c] = mdl[r][c] + p[ACC_W-1:0];
                end
    endtask

    task automatic do_start(input bit acc, input int k);
        chk("busy_before_start", CW'(busy), CW'(1'b0));
        start = 1'b1; acc_mode = acc; k_len = KLEN_W'(k);
        @(posedge clk); #1;
        start = 1'b0; acc_mode = 1'b0; k_len = '0;
        chk("busy_after_start", CW'(busy), CW'(1'b1));
    endtask

    task automatic do_feed(input int n, input int bub);
        int i = 0;
        int g = 0;
        while (i < n && g < 1000) begin
            chk("in_ready_load", CW'(in_ready), CW'(1'b1));
            in_valid = ($urandom_range(0, 99) >= bub);
            for (int r = 0; r < ROWS; r++)
                a_vec[r*DATA_W +: DATA_W] = in_valid ? op_a[i][r] : DATA_W'($urandom);
            for (int c = 0; c < COLS; c++)
                b_vec[c*DATA_W +: DATA_W] = in_valid ? op_b[i][c] : DATA_W'($urandom);
            if (in_valid) i++;
            @(posedge clk); #1;
            g++;
        end
        in_valid = 1'b0;
        if (g >= 1000) chk("feed_timeout", CW'(i), CW'(n));
    endtask

    // Stray in_valid and start pulses here must have no effect outside LOAD/IDLE.
    task automatic wait_drain(input int exp_lat);
        int cyc = 0;
        while (!out_valid && cyc < 100) begin
            chk("in_ready_flush", CW'(in_ready), CW'(1'b0));
            in_valid = 1'b1;
            a_vec = {ROWS{DATA_W'($urandom)}};
            b_vec = {COLS{DATA_W'($urandom)}};
            start = (cyc == 0); acc_mode = 1'b0; k_len = KLEN_W'(3);
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0; start = 1'b0; k_len = '0;
        chk("flush_latency", CW'(cyc), CW'(exp_lat));
    endtask

    task automatic do_drain(input int stall, input int nrows);
        int row = 0;
        int g = 0;
        while (row < nrows && g < 2000) begin
            out_ready = ($urandom_range(0, 99) >= stall);
            in_valid  = 1'($urandom_range(0, 1));
            chk($sformatf("out_valid_r%0d", row), CW'(out_valid), CW'(1'b1));
            chk($sformatf("out_idx_r%0d", row), CW'(out_idx), CW'(row));
            chk($sformatf("out_row_r%0d", row), out_row, model_row(row));
            if (use_exp) chk($sformatf("out_row_const_r%0d", row), out_row, exp_row);
            chk("done_mid_drain", CW'(done), CW'(1'b0));
            chk("in_ready_drain", CW'(in_ready), CW'(1'b0));
            if (out_ready) row++;
            @(posedge clk); #1;
            g++;
        end
        out_ready = 1'b0; in_valid = 1'b0;
        if (g >= 2000) chk("drain_timeout", CW'(row), CW'(nrows));
        if (nrows == ROWS) begin
            chk("done_pulse", CW'(done), CW'(1'b1));
            chk("out_valid_after", CW'(out_valid), CW'(1'b0));
            chk("busy_after", CW'(busy), CW'(1'b0));
            chk("out_idx_after", CW'(out_idx), CW'(0));
            @(posedge clk); #1;
            chk("done_one_cycle", CW'(done), CW'(1'b0));
        end
    endtask

    task automatic run_tile(input tile_t t);
        gen_ops(t);
        do_start(t.acc, t.k);
        model_tile(t.acc, t.k);
        if (t.k > 0) do_feed(t.k, t.bub);
        wait_drain((t.k > 0) ? ROWS + COLS - 1 : 0);
        do_drain(t.stall, ROWS);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  CW'(in_ready),  CW'(1'b0));
        chk({tag, "_out_valid"}, CW'(out_valid), CW'(1'b0));
        chk({tag, "_out_row"},   out_row,        CW'(0));
        chk({tag, "_out_idx"},   CW'(out_idx),   CW'(0));
        chk({tag, "_busy"},      CW'(busy),      CW'(1'b0));
        chk({tag, "_done"},      CW'(done),      CW'(1'b0));
    endtask

    initial begin
        tile_t t;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        tbl[0] = mk(1'b0, 4, 1, 1, 0, 0, 0, 0, 1'b0, 0);
        tbl[1] = mk(1'b0, 3, 0, 0, -2, 3, 40, 0, 1'b1, -18);
        tbl[2] = mk(1'b0, 2, 0, 0, 1, 1, 0, 0, 1'b1, 2);
        tbl[3] = mk(1'b1, 2, 0, 0, 1, 1, 0, 0, 1'b1, 4);
        tbl[4] = mk(1'b0, 1, 0, 0, 1, 1, 0, 0, 1'b1, 1);
        tbl[5] = mk(1'b0, 2, 0, 0, -32768, -32768, 0, 0, 1'b1, 64'sh8000_0000);
        tbl[6] = mk(1'b1, 0, 0, 0, 0, 0, 0, 50, 1'b1, 64'sh8000_0000);
        tbl[7] = mk(1'b0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 0);
        tbl[8] = mk(1'b0, 5, 2, 2, 0, 0, 30, 50, 1'b0, 0);
        for (int i = 0; i < 9; i++) run_tile(tbl[i]);

        for (int i = 0; i < 6; i++) begin
            t = mk(1'($urandom_range(0, 1)), $urandom_range(0, 8), 2, 2, 0, 0,
                   $urandom_range(0, 50), $urandom_range(0, 60), 1'b0, 0);
            run_tile(t);
        end

        // reset during LOAD, then accumulate onto what must be cleared state
        t = mk(1'b0, 4, 2, 2, 0, 0, 0, 0, 1'b0, 0);
        gen_ops(t);
        do_start(1'b0, 4);
        do_feed(2, 0);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("rst_load");
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_model();
        @(posedge clk); #1;
        run_tile(mk(1'b1, 2, 0, 0, 1, 1, 0, 0, 1'b1, 2));

        // reset during DRAIN after two rows
        t = mk(1'b0, 1, 0, 0, 5, 5, 0, 0, 1'b1, 25);
        gen_ops(t);
        do_start(1'b0, 1);
        model_tile(1'b0, 1);
        do_feed(1, 0);
        wait_drain(ROWS + COLS - 1);
        do_drain(0, 2);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("rst_drain");
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_model();
        @(posedge clk); #1;
        run_tile(mk(1'b1, 1, 0, 0, 1, 1, 0, 30, 1'b1, 1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
